// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the multicycle control path and the
// iterative multiply/divide unit.
interface muldiv_seq_if #(
   parameter int WIDTH = 16
) ();
   logic             req;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   logic             div_by_zero;

   // Requester side: drives the operation, observes status and results.
   modport master (
      output req, op, a, b,
      input  busy, done, result_lo, result_hi, div_by_zero
   );

   // Unit side: samples the operation, produces status and results.
   modport slave (
      input  req, op, a, b,
      output busy, done, result_lo, result_hi, div_by_zero
   );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential unsigned multiply / divide unit.
// One bit per cycle: shift-add multiply or restoring divide, WIDTH iterations,
// then a one-cycle DONE with registered results. Divide by zero skips RUN.
module muldiv_seq #(
   parameter int WIDTH = 16,
   parameter int CW    = 5
) (
   input  logic         clk,
   input  logic         start_n,
   muldiv_seq_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             op_q, op_d;
   // Multiplicand (multiply) or divisor (divide).
   logic [WIDTH-1:0] opnd_q, opnd_d;
   // Upper accumulator half (multiply) or partial remainder (divide).
   logic [WIDTH-1:0] hi_q, hi_d;
   // Multiplier being shifted out (multiply) or dividend/quotient (divide).
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] res_lo_q, res_lo_d;
   logic [WIDTH-1:0] res_hi_q, res_hi_d;
   logic             dbz_q, dbz_d;

   // One iteration worth of datapath results.
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH+1:0] div_trial;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;
   logic             unused_trial_bit;

   // Single iteration of the active algorithm. The partial remainder is kept in
   // WIDTH bits because after each step it is always below the divisor; the
   // WIDTH+1-bit shifted remainder exists only in the trial-subtract path.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
      div_shift = {hi_q, lo_q[WIDTH-1]};
      div_trial = {1'b0, div_shift} - {2'b00, opnd_q};
      step_hi   = mul_sum[WIDTH:1];
      step_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
      if (op_q) begin
         if (!div_trial[WIDTH+1]) begin
            step_hi = div_trial[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = div_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Bit WIDTH of a non-negative trial is always zero; it carries no information.
   assign unused_trial_bit = div_trial[WIDTH];

   // Next-state and datapath control: accept in IDLE, iterate in RUN, pulse DONE.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      dbz_d    = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req) begin
               op_d  = bus.op;
               cnt_d = '0;
               hi_d  = '0;
               dbz_d = 1'b0;
               if (bus.op) begin
                  opnd_d = bus.b;
                  lo_d   = bus.a;
               end else begin
                  opnd_d = bus.a;
                  lo_d   = bus.b;
               end
               if (bus.op && (bus.b == '0)) begin
                  state_d  = S_DONE;
                  res_lo_d = '1;
                  res_hi_d = bus.a;
                  dbz_d    = 1'b1;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d  = S_DONE;
               res_lo_d = step_lo;
               res_hi_d = step_hi;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk) begin
      if (!start_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= 1'b0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         opnd_q   <= opnd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         dbz_q    <= dbz_d;
      end
   end

   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = (state_q == S_DONE);
   assign bus.result_lo   = res_lo_q;
   assign bus.result_hi   = res_hi_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expectations are queued when an operation is
// issued and checked (values and done cycle) when done pulses.
module tb_muldiv_seq;

   localparam int W = 16;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         dbz;
      int           cyc;
   } exp_t;

   logic clk;
   logic start_n;
   int   cyc;
   int   n_tests;
   int   n_fail;
   exp_t sb[$];
   exp_t mon_e;
   exp_t last_e;

   logic         b2b_op[3];
   logic [W-1:0] b2b_a[3];
   logic [W-1:0] b2b_b[3];

   muldiv_seq_if #(.WIDTH(W)) bus ();

   muldiv_seq #(.WIDTH(W), .CW(5)) dut (
      .clk     (clk),
      .start_n (start_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic op_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v);
      exp_t        e;
      logic [31:0] prod;
      e.cyc = 0;
      if (!op_v) begin
         prod  = {16'h0, a_v} * {16'h0, b_v};
         e.lo  = prod[15:0];
         e.hi  = prod[31:16];
         e.dbz = 1'b0;
      end else if (b_v == 0) begin
         e.lo  = 16'hFFFF;
         e.hi  = a_v;
         e.dbz = 1'b1;
      end else begin
         e.lo  = a_v / b_v;
         e.hi  = a_v % b_v;
         e.dbz = 1'b0;
      end
      return e;
   endfunction

   // Result monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            check_val("spurious_done", 64'd1, 64'd0);
         end else begin
            mon_e = sb.pop_front();
            $display("[TB] done cyc=%0d lo=0x%04h hi=0x%04h dbz=%0b", cyc,
                     bus.result_lo, bus.result_hi, bus.div_by_zero);
            check_val("result_lo", 64'(bus.result_lo), 64'(mon_e.lo));
            check_val("result_hi", 64'(bus.result_hi), 64'(mon_e.hi));
            check_val("div_by_zero", 64'(bus.div_by_zero), 64'(mon_e.dbz));
            check_val("done_cycle", 64'(cyc), 64'(mon_e.cyc));
         end
      end
   end

   task automatic wait_drain(input string tag);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         check_val(tag, 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   // Issue one operation from IDLE with a one-cycle req.
   task automatic do_op(input logic op_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v);
      exp_t e;
      logic dz;
      dz = op_v && (b_v == 0);
      @(posedge clk); #1;
      bus.req = 1'b1;
      bus.op  = op_v;
      bus.a   = a_v;
      bus.b   = b_v;
      e       = model(op_v, a_v, b_v);
      e.cyc   = cyc + (dz ? 1 : W + 1);
      sb.push_back(e);
      last_e  = e;
      @(posedge clk); #1;
      bus.req = 1'b0;
      bus.op  = 1'($urandom);
      bus.a   = 16'($urandom);
      bus.b   = 16'($urandom);
      check_val("busy_after_accept", 64'(bus.busy), 64'd1);
      check_val("dbz_after_accept", 64'(bus.div_by_zero), 64'(dz));
      wait_drain("op_timeout");
   endtask

   // Results must hold in IDLE until the next operation completes.
   task automatic hold_check();
      repeat (3) @(posedge clk);
      #1;
      check_val("idle_busy", 64'(bus.busy), 64'd0);
      check_val("hold_lo", 64'(bus.result_lo), 64'(last_e.lo));
      check_val("hold_hi", 64'(bus.result_hi), 64'(last_e.hi));
      check_val("hold_dbz", 64'(bus.div_by_zero), 64'(last_e.dbz));
   endtask

   // req held high for three operations; operands valid only in accept cycles.
   task automatic back_to_back();
      int   n0;
      int   idx;
      exp_t e;
      @(posedge clk); #1;
      n0 = cyc;
      for (int o = 0; o <= 54; o++) begin
         if (o == 0 || o == 18 || o == 36) begin
            idx     = o / 18;
            bus.req = 1'b1;
            bus.op  = b2b_op[idx];
            bus.a   = b2b_a[idx];
            bus.b   = b2b_b[idx];
            e       = model(b2b_op[idx], b2b_a[idx], b2b_b[idx]);
            e.cyc   = n0 + o + W + 1;
            sb.push_back(e);
            last_e  = e;
         end else begin
            bus.req = (o < 36);
            bus.op  = 1'($urandom);
            bus.a   = 16'($urandom);
            bus.b   = 16'($urandom);
         end
         @(posedge clk); #1;
      end
      bus.req = 1'b0;
      wait_drain("b2b_timeout");
   endtask

   // Reset during the eighth RUN cycle of a multiply: nothing may complete.
   task automatic reset_mid_op();
      @(posedge clk); #1;
      bus.req = 1'b1;
      bus.op  = 1'b0;
      bus.a   = 16'h1234;
      bus.b   = 16'h5678;
      @(posedge clk); #1;
      bus.req = 1'b0;
      repeat (7) begin
         @(posedge clk); #1;
      end
      start_n = 1'b0;
      @(negedge clk);
      check_val("busy_before_reset", 64'(bus.busy), 64'd1);
      @(posedge clk); #1;
      start_n = 1'b1;
      check_val("rst_busy", 64'(bus.busy), 64'd0);
      check_val("rst_done", 64'(bus.done), 64'd0);
      check_val("rst_lo", 64'(bus.result_lo), 64'd0);
      check_val("rst_hi", 64'(bus.result_hi), 64'd0);
      check_val("rst_dbz", 64'(bus.div_by_zero), 64'd0);
      repeat (25) @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      b2b_op[0] = 1'b0; b2b_a[0] = 16'h00FF; b2b_b[0] = 16'h0101;
      b2b_op[1] = 1'b1; b2b_a[1] = 16'hFFFF; b2b_b[1] = 16'h0010;
      b2b_op[2] = 1'b0; b2b_a[2] = 16'h8000; b2b_b[2] = 16'h0002;
      start_n = 1'b0;
      bus.req = 1'b0;
      bus.op  = 1'b0;
      bus.a   = '0;
      bus.b   = '0;
      repeat (2) @(posedge clk);
      #1;
      check_val("reset_busy", 64'(bus.busy), 64'd0);
      check_val("reset_done", 64'(bus.done), 64'd0);
      check_val("reset_lo", 64'(bus.result_lo), 64'd0);
      check_val("reset_hi", 64'(bus.result_hi), 64'd0);
      check_val("reset_dbz", 64'(bus.div_by_zero), 64'd0);
      start_n = 1'b1;

      do_op(1'b0, 16'h1234, 16'h5678); hold_check();
      do_op(1'b0, 16'hFFFF, 16'hFFFF); hold_check();
      do_op(1'b0, 16'h0000, 16'h1234); hold_check();
      do_op(1'b1, 16'd1000, 16'd7);    hold_check();
      do_op(1'b1, 16'd5,    16'd9);    hold_check();
      do_op(1'b1, 16'h00AB, 16'h0000); hold_check();
      do_op(1'b1, 16'd100,  16'd3);    hold_check();

      back_to_back();
      hold_check();

      do_op(1'b1, 16'h00AB, 16'h0000);
      reset_mid_op();
      do_op(1'b0, 16'h00C3, 16'h0F0F); hold_check();

      for (int i = 0; i < 6; i++) begin
         do_op(1'($urandom), 16'($urandom), 16'($urandom_range(1, 65535)));
      end
      hold_check();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
